// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the UART receiver slice.
// The optional parity stage is enabled with the UART_RX_PARITY_EN macro.
package uart_pkg;

    localparam int   DEFAULT_NO_OF_SAMPLE = 16;
    localparam int   DEFAULT_DATA_BITS    = 8;
    localparam logic IDLE_LEVEL           = 1'b1;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE      = 3'd0;
    localparam rx_state_t ST_START     = 3'd1;
    localparam rx_state_t ST_DATA      = 3'd2;
    localparam rx_state_t ST_PARITY    = 3'd3;
    localparam rx_state_t ST_STOP      = 3'd4;
    localparam rx_state_t ST_WAIT_IDLE = 3'd5;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: received word, result pulses and frame-in-progress flag.
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
    parameter int data_bits = 8
);
    logic                 rx_active;
    logic [data_bits-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;

    modport master (output rx_active, rx_data, rx_valid, frame_err, parity_err);
    modport slave  (input  rx_active, rx_data, rx_valid, frame_err, parity_err);
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to the line idle level so reset never looks like a start bit.
module uart_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/(parity)/stop framing with error pulses.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int no_of_sample = DEFAULT_NO_OF_SAMPLE,
    parameter int data_bits    = DEFAULT_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_in,
    input  logic      baud_en_rx,
    uart_rx_if.master rx_if
);
    localparam int CW = $clog2(no_of_sample);
    localparam int BW = $clog2(data_bits);
    localparam logic [CW-1:0] HALF_TICK = CW'(no_of_sample / 2 - 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(no_of_sample - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(data_bits - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [data_bits-1:0] shift_q, shift_d;
    logic [data_bits-1:0] data_q, data_d;
    logic                 rx_prev_q, rx_prev_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        rx_prev_d = rx_s;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // rx_prev_q resets low, so the line must be seen high before an edge counts
                if (rx_prev_q && !rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (baud_en_rx) begin
                    if (tick_q == HALF_TICK) begin
                        tick_d  = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_en_rx) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[data_bits-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_en_rx) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d    = '0;
                        par_bad_d = (^shift_q) ^ rx_s;
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (baud_en_rx) begin
                    if (tick_q == LAST_TICK) begin
                        tick_d = '0;
`ifdef UART_RX_PARITY_EN
                        perr_d = par_bad_q;
                        if (rx_s && !par_bad_q) begin
`else
                        if (rx_s) begin
`endif
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            rx_prev_q <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rx_prev_q <= rx_prev_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_if.rx_active = (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE);
    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected results, a monitor pops them.
// Honours UART_RX_PARITY_EN by inserting the parity bit and running the parity cases.
module tb_uart_rx;
    localparam int NS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in = 1'b1;
    logic baud_en_rx = 1'b0;

    int baud_div = 1;
    int baud_cnt = 0;
    int vectors_applied = 0;
    int miscompares = 0;
    logic [7:0] last_good = 8'h00;

    // each entry is {rx_valid, frame_err, parity_err, rx_data}
    logic [10:0] exp_q[$];
    logic [10:0] exp_item;
    logic [10:0] act_item;

    uart_rx_if #(.data_bits(8)) rx_if ();

    uart_rx #(.no_of_sample(NS), .data_bits(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .baud_en_rx (baud_en_rx),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (baud_cnt >= baud_div - 1) begin
                baud_en_rx = 1'b1;
                baud_cnt   = 0;
            end else begin
                baud_en_rx = 1'b0;
                baud_cnt   = baud_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_if.rx_valid || rx_if.frame_err || rx_if.parity_err)) begin
            act_item = {rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err, rx_if.rx_data};
            if (exp_q.size() == 0) begin
                vectors_applied++;
                miscompares++;
                $display("[TB] FAIL unexpected_pulse: got 0x%0h, required no pulse at %0t", act_item, $time);
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput("scoreboard", {21'd0, act_item}, {21'd0, exp_item});
            end
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (baud_en_rx) k++;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        rx_in = v;
        wait_ticks(n);
    endtask

    // Sends one frame; par_ok selects a correct or deliberately wrong parity bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_ok,
                                 input int stop_ticks);
        logic good;
        logic perr_exp;
`ifdef UART_RX_PARITY_EN
        perr_exp = !par_ok;
`else
        perr_exp = 1'b0;
`endif
        good = stop_bit && !perr_exp;
        exp_q.push_back({good, !stop_bit, perr_exp, good ? data : last_good});
        if (good) last_good = data;
        drive_bit(1'b0, NS);
        @(negedge clk);
        checkOutput("rx_active_in_frame", {31'd0, rx_if.rx_active}, 32'd1);
        rx_in = data[0];
        wait_ticks(NS);
        for (int i = 1; i < 8; i++) drive_bit(data[i], NS);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? ^data : ~^data, NS);
`endif
        drive_bit(stop_bit, stop_ticks);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_rx_active"}, {31'd0, rx_if.rx_active}, 32'd0);
        checkOutput({tag, "_rx_data"}, {24'd0, rx_if.rx_data}, 32'd0);
        checkOutput({tag, "_rx_valid"}, {31'd0, rx_if.rx_valid}, 32'd0);
        checkOutput({tag, "_frame_err"}, {31'd0, rx_if.frame_err}, 32'd0);
        checkOutput({tag, "_parity_err"}, {31'd0, rx_if.parity_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        drive_bit(1'b1, 2 * NS);

        $display("[TB] good frame 0x55");
        applyStimulus(8'h55, 1'b1, 1'b1, NS);
        @(negedge clk);
        checkOutput("rx_active_after_stop", {31'd0, rx_if.rx_active}, 32'd0);
        checkOutput("rx_data_after_55", {24'd0, rx_if.rx_data}, 32'h55);

        $display("[TB] start-bit glitch");
        drive_bit(1'b0, 4);
        @(negedge clk);
        checkOutput("glitch_active", {31'd0, rx_if.rx_active}, 32'd1);
        rx_in = 1'b1;
        wait_ticks(2 * NS);
        @(negedge clk);
        checkOutput("glitch_back_idle", {31'd0, rx_if.rx_active}, 32'd0);

        $display("[TB] frame error 0xA3 with line held low");
        applyStimulus(8'hA3, 1'b0, 1'b1, 40);
        @(negedge clk);
        checkOutput("ferr_wait_idle_active", {31'd0, rx_if.rx_active}, 32'd0);
        checkOutput("ferr_rx_data_kept", {24'd0, rx_if.rx_data}, 32'h55);
        drive_bit(1'b1, 2 * NS);
        applyStimulus(8'h5A, 1'b1, 1'b1, NS);
        drive_bit(1'b1, NS);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity cases 0x07");
        applyStimulus(8'h07, 1'b1, 1'b0, NS);
        drive_bit(1'b1, NS);
        checkOutput("perr_rx_data_kept", {24'd0, rx_if.rx_data}, 32'h5A);
        applyStimulus(8'h07, 1'b1, 1'b1, NS);
        drive_bit(1'b1, NS);
`endif

        $display("[TB] reset during data bit 3 of 0xFF");
        drive_bit(1'b0, NS);
        drive_bit(1'b1, 3 * NS + NS / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        rst = 1'b0;
        last_good = 8'h00;
        drive_bit(1'b1, 8 * NS);
        applyStimulus(8'h3C, 1'b1, 1'b1, NS);
        drive_bit(1'b1, NS);
        checkOutput("rx_data_after_3c", {24'd0, rx_if.rx_data}, 32'h3C);

        $display("[TB] back-to-back 0x12 0x34, tick every 3rd cycle");
        baud_div = 3;
        drive_bit(1'b1, NS);
        applyStimulus(8'h12, 1'b1, 1'b1, NS);
        applyStimulus(8'h34, 1'b1, 1'b1, NS);
        drive_bit(1'b1, 2 * NS);
        checkOutput("rx_data_after_34", {24'd0, rx_if.rx_data}, 32'h34);

        checkOutput("results_outstanding", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
